tt_um_johnson_decoder: RTL
==========================

# tt_um_johnson_decoder

Receive-side companion to the 8-bit Johnson counter tile. The block samples an external 8-bit Johnson code and decodes it to a 4-bit phase index. It checks every sample for code validity and for sequence continuity, and acquires and holds lock on a running counter. Continuity errors are counted in a saturating register so a bench or a second tile can qualify a Johnson source over the chip I/O.

## Interface
Parameters:
- LOCK_CNT, default 4: number of consecutive legal successor transitions needed to enter LOCKED (range 1..7).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- ena  input  1  tile enable; 0 = no sample, all state holds.
- ui_in  input  8  Johnson code under test.
- uio_in  input  8  [0] sample_en: accept ui_in this cycle. [1] clr_err: clear the error counter. [7:2] ignored.
- uo_out  output  8  [3:0] idx, decoded phase 0..15. [4] code_ok. [5] locked. [6] seq_err, 1-cycle pulse. [7] err_sat, error counter = 15.
- uio_out  output  8  [7:4] err_cnt. [3:0] = 0.
- uio_oe  output  8  constant 8'hF0.

## Operation
- A sample occurs when ena=1 and sample_en=1. With no sample, all state holds and seq_err is 0.
- Legal codes (16 total):
  - Phase k=0..8: low k bits set, i.e. 0x00, 0x01, 0x03, …, 0xFF.
  - Phase k=9..15: 8'hFF << (k-8), i.e. 0xFE, 0xFC, …, 0x80.
- Successor of legal code c is {c[6:0], ~c[7]}. Sequence: 0x7F→0xFF→0xFE, and 0x80→0x00 wraps phase 15 to phase 0.
- Sample classification (prev = last legal sampled code; have_prev = prev is defined):
  - BAD: ui_in is not a legal code.
  - HOLD: legal, have_prev=1, and ui_in == prev.
  - STEP: legal, have_prev=1, and ui_in == successor(prev).
  - JUMP: legal, but have_prev=0 or neither HOLD nor STEP.
- Updates on every sample:
  - code_ok is set to (class != BAD).
  - On a legal sample: idx is set to the decoded phase, prev is set to ui_in, have_prev is set to 1.
  - On a BAD sample: idx, prev and have_prev hold.
- FSM, two states, reset state ACQUIRE. run is a 3-bit count of consecutive STEP samples.
  - ACQUIRE, STEP: run++. If the new run equals LOCK_CNT, go to LOCKED and clear run.
  - ACQUIRE, HOLD: run holds.
  - ACQUIRE, BAD or JUMP: run=0. No error is counted.
  - LOCKED, STEP or HOLD: stay in LOCKED.
  - LOCKED, BAD or JUMP: seq_err=1 for one cycle, err_cnt increments, go to ACQUIRE, run=0.
  - A JUMP in LOCKED still updates prev, so reacquisition starts from the new code.
- err_cnt is 4 bits and saturates at 15; err_sat = (err_cnt == 15).
- clr_err sets err_cnt to 0. It applies when ena=1, independent of sample_en. When clr_err coincides with an increment, the result is 0 (clear wins).
- locked = (state == LOCKED).

## Timing
- All outputs are registered. A sample at edge N is reflected on idx, code_ok, locked, seq_err and err_cnt after edge N.
- Lock latency: the first legal sample plus LOCK_CNT STEP samples. With LOCK_CNT=4, locked rises after the 5th sample edge.
- seq_err is high for exactly one cycle per error, including when err_cnt is already saturated.
- Reset (rst_n=0 at an edge): idx=0, code_ok=0, locked=0, seq_err=0, err_cnt=0, run=0, have_prev=0, state=ACQUIRE, uo_out=0x00, uio_out=0x00. Reset wins over every other input, including mid-lock.
- uio_oe = 0xF0 in all cycles, including during reset.

## Test plan
- Reset, then sample 0x00,0x01,0x03,0x07,0x0F every cycle → idx = 0,1,2,3,4; code_ok=1; locked=1 after the 5th sample; err_cnt=0.
- From lock at 0xFF, sample 0xFE, then 0xFE again (HOLD), then 0xFC → idx = 9,9,10; locked stays 1; no seq_err.
- Wrap: locked at 0xC0, sample 0x80,0x00,0x01 → idx = 15,0,1; locked stays 1.
- While locked, sample 0x55 → code_ok=0, idx holds, seq_err pulse, err_cnt=1, locked=0. Next sample 0x0F (JUMP in ACQUIRE) → no count; then 4 STEPs relock.
- Force 17 lock/JUMP error cycles → err_cnt=15, err_sat=1, seq_err still pulses. Assert clr_err together with an error sample → err_cnt=0.
- ena=0 with sample_en=1 and varying ui_in for 10 cycles → all outputs unchanged. Assert rst_n=0 while locked → uo_out=0x00 and uio_out=0x00 on the next edge.

Source files
------------

// File: rtl/tt_um_johnson_decoder.sv
// Johnson code receiver: decodes an 8-bit Johnson code to a phase index,
// checks validity and continuity, tracks lock and counts continuity errors.
module tt_um_johnson_decoder #(
    parameter int LOCK_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] run_q, run_d;
    logic [3:0] idx_q, idx_d;
    logic       code_ok_q, code_ok_d;
    logic       seq_err_q, seq_err_d;
    logic [3:0] err_q, err_d;
    logic [7:0] prev_q, prev_d;
    logic       have_prev_q, have_prev_d;

    logic       sample;
    logic       clr_err;
    logic       legal;
    logic [3:0] phase;
    logic [7:0] succ;
    logic       is_hold;
    logic       is_step;
    logic [2:0] run_inc;
    logic       unused_ok;

    assign sample    = ena & uio_in[0];
    assign clr_err   = ena & uio_in[1];
    assign unused_ok = &{1'b0, uio_in[7:2]};

    // Phase k: k low ones for k<=8, then ones shifted out from the bottom.
    function automatic logic [7:0] jcode(input int k);
        if (k <= 8) begin
            return 8'hFF >> (8 - k);
        end
        return 8'hFF << (k - 8);
    endfunction

    always_comb begin
        legal = 1'b0;
        phase = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (ui_in == jcode(k)) begin
                legal = 1'b1;
                phase = 4'(k);
            end
        end
    end

    assign succ    = {prev_q[6:0], ~prev_q[7]};
    assign is_hold = legal & have_prev_q & (ui_in == prev_q);
    assign is_step = legal & have_prev_q & (ui_in == succ);
    assign run_inc = run_q + 3'd1;

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        idx_d       = idx_q;
        code_ok_d   = code_ok_q;
        seq_err_d   = 1'b0;
        err_d       = err_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;

        if (sample) begin
            code_ok_d = legal;
            if (legal) begin
                idx_d       = phase;
                prev_d      = ui_in;
                have_prev_d = 1'b1;
            end
            unique case (state_q)
                ACQUIRE: begin
                    unique case (1'b1)
                        is_step: begin
                            if (run_inc == 3'(LOCK_CNT)) begin
                                state_d = LOCKED;
                                run_d   = 3'd0;
                            end else begin
                                run_d = run_inc;
                            end
                        end
                        is_hold: run_d = run_q;
                        default: run_d = 3'd0;
                    endcase
                end
                LOCKED: begin
                    if (!(is_step || is_hold)) begin
                        seq_err_d = 1'b1;
                        state_d   = ACQUIRE;
                        run_d     = 3'd0;
                        if (err_q != 4'd15) begin
                            err_d = err_q + 4'd1;
                        end
                    end
                end
                default: state_d = ACQUIRE;
            endcase
        end

        if (clr_err) begin
            err_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACQUIRE;
            run_q       <= 3'd0;
            idx_q       <= 4'd0;
            code_ok_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            err_q       <= 4'd0;
            prev_q      <= 8'd0;
            have_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            idx_q       <= idx_d;
            code_ok_q   <= code_ok_d;
            seq_err_q   <= seq_err_d;
            err_q       <= err_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign uo_out = {
        (err_q == 4'd15),
        seq_err_q,
        (state_q == LOCKED),
        code_ok_q,
        idx_q
    };
    assign uio_out = {err_q, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule
